// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) used for bubbles.
//   fetch_entry_t : one prefetch-queue entry {pc, instr} at the default XLEN.
//   XLEN_DEFAULT / DEPTH_DEFAULT : default parameter values for the stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of fetch entries.
//   clk, rst   : clock, asynchronous active-high reset (queue empty).
//   push/push_data : write one entry (ignored when full unless popping).
//   pop        : remove the head entry (ignored when empty).
//   clear      : empty the queue; wins over push and pop.
//   head       : entry at the head; valid only when !empty. No bypass.
//   count/full/empty : occupancy status.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  entry_t          push_data,
  input  logic            pop,
  input  logic            clear,
  output entry_t          head,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so PtrW-bit increments wrap by masking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem requests,
// prefetch queue and the IF/ID pipeline register.
//   clk, rst          : clock, asynchronous active-high reset.
//   imem_req_*        : request channel (valid/ready, address = fetch PC).
//   imem_rsp_*        : in-order responses, one per accepted request.
//   redirect_valid/pc : taken branch/jump from execute.
//   stall_d, flush_d  : hold / bubble the IF/ID register.
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register outputs.
//   fq_count          : prefetch queue occupancy.
module fetch_prefetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int unsigned    CntW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic [CntW-1:0] fq_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;
  logic [31:0]     instr_d_q, instr_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic            valid_d_q, valid_d_d;

  entry_t          push_entry, head;
  logic [CntW-1:0] q_count;
  logic            q_full, q_empty;
  logic            rsp_fire, req_fire, push, pop, advance, room;

  assign rsp_fire = imem_rsp_valid && outstanding_q;
  assign push     = rsp_fire && !drop_q && !redirect_valid;
  assign advance  = !redirect_valid && !flush_d && !stall_d;
  assign pop      = advance && !q_empty;

  // Count an entry being pushed this cycle so the queue can never overflow.
  assign room = ({1'b0, q_count} + (CntW + 1)'(push)) < (CntW + 1)'(DEPTH);

  assign imem_req_valid = !outstanding_q && !redirect_valid && room;
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push_entry = '{pc: out_pc_q, instr: imem_rsp_data};

  always_comb begin
    fpc_d         = fpc_q;
    out_pc_d      = out_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (req_fire) begin
      outstanding_d = 1'b1;
      out_pc_d      = fpc_q;
      fpc_d         = fpc_q + XLEN'(4);
    end
    if (rsp_fire) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (redirect_valid) begin
      fpc_d = redirect_pc;
      // The in-flight response belongs to the old path; discard it on arrival.
      if (outstanding_q && !imem_rsp_valid) drop_d = 1'b1;
    end
  end

  always_comb begin
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    if (redirect_valid || flush_d) begin
      valid_d_d = 1'b0;
      instr_d_d = NOP_INSTR;
    end else if (stall_d) begin
      valid_d_d = valid_d_q;
    end else if (!q_empty) begin
      instr_d_d    = head.instr;
      pc_d_d       = head.pc;
      pc_plus4_d_d = head.pc + XLEN'(4);
      valid_d_d    = 1'b1;
    end else begin
      valid_d_d = 1'b0;
      instr_d_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      out_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      instr_d_q     <= NOP_INSTR;
      pc_d_q        <= '0;
      pc_plus4_d_q  <= '0;
      valid_d_q     <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      out_pc_q      <= out_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      instr_d_q     <= instr_d_d;
      pc_d_q        <= pc_d_d;
      pc_plus4_d_q  <= pc_plus4_d_d;
      valid_d_q     <= valid_d_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_valid),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign instr_d    = instr_d_q;
  assign pc_d       = pc_d_q;
  assign pc_plus4_d = pc_plus4_d_q;
  assign valid_d    = valid_d_q;
  assign fq_count   = q_count;

endmodule
